// File: rtl/uart_buf_rd_sched_pkg.sv
// Shared types and constants for the UART receive-buffer read scheduler.
// Optional feature macro: DROP_CNT_EN (adds a saturating drop counter).
package uart_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARB,
      READ,
      DONE
   } state_t;

   localparam int unsigned DEF_NCH   = 5;
   localparam int unsigned DEF_AW    = 5;
   localparam int unsigned DEF_WORDS = 20;
   localparam int unsigned DEF_GAP   = 3;

   // Tag travelling alongside the buffer read data through the latency pipe.
   typedef struct packed {
      logic       valid;
      logic [2:0] ch;
      logic       first;
      logic       last;
   } vtag_t;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned chW(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_buf_rd_sched_if.sv
// Handshake bundle between the write counters, the read scheduler and the packers.
// Optional feature macro: DROP_CNT_EN (adds oDropCnt).
interface uart_buf_rd_sched_if #(
   parameter int unsigned NCH = 5,
   parameter int unsigned AW  = 5
);
   logic [NCH-1:0] iDone;
   logic [NCH-1:0] oRd;
   logic [AW-1:0]  oRdAdr;
   logic           oValid;
   logic [2:0]     oValCh;
   logic           oFirst;
   logic           oLast;
   logic           oBusy;
   logic           oOvf;
`ifdef DROP_CNT_EN
   logic [7:0]     oDropCnt;

   modport master (
      input  iDone,
      output oRd, oRdAdr, oValid, oValCh, oFirst, oLast, oBusy, oOvf, oDropCnt
   );
   modport slave (
      output iDone,
      input  oRd, oRdAdr, oValid, oValCh, oFirst, oLast, oBusy, oOvf, oDropCnt
   );
`else
   modport master (
      input  iDone,
      output oRd, oRdAdr, oValid, oValCh, oFirst, oLast, oBusy, oOvf
   );
   modport slave (
      output iDone,
      input  oRd, oRdAdr, oValid, oValCh, oFirst, oLast, oBusy, oOvf
   );
`endif
endinterface

// File: rtl/uart_buf_rd_sched_rr_pick.sv
// Combinational round-robin priority encoder: first requester after 'last'.
module rr_pick
   import uart_sched_pkg::*;
#(
   parameter int unsigned NCH = 5,
   parameter int unsigned CW  = chW(NCH)
)(
   input  logic [NCH-1:0] req,
   input  logic [CW-1:0]  last,
   output logic [CW-1:0]  grant,
   output logic           found
);

   int unsigned    idx;
   logic [NCH-1:0] rot;

   // Scan (last+1)..(last+NCH) mod NCH and keep the first hit.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      rot   = '0;
      for (int unsigned k = 1; k <= NCH; k++) begin
         idx = (32'(last) + k) % NCH;
         rot = req >> idx;
         if (!found && rot[0]) begin
            grant = CW'(idx);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_buf_rd_sched.sv
// Round-robin read scheduler for the per-channel ramUART receive buffers.
// Grants one channel per packet, walks WORDS addresses with GAP idle cycles
// between reads, and tags the buffer output with a latency-aligned valid.
// Optional feature macro: DROP_CNT_EN (saturating count of oOvf pulses).
module uart_buf_rd_sched
   import uart_sched_pkg::*;
#(
   parameter int unsigned NCH    = DEF_NCH,
   parameter int unsigned AW     = DEF_AW,
   parameter int unsigned WORDS  = DEF_WORDS,
   parameter int unsigned GAP    = DEF_GAP,
   parameter int unsigned RD_LAT = 1
)(
   input  logic clk,
   input  logic rst,
   uart_buf_rd_sched_if.master bus
);

   localparam int unsigned CH_W = chW(NCH);
   localparam int unsigned GW   = chW(GAP + 1);

   if ((WORDS < 1) || (WORDS > (1 << AW)) || (NCH < 1) || (NCH > 8) || (RD_LAT < 1)) begin : gBadCfg
      $error("uart_buf_rd_sched: WORDS must be 1..2**AW, NCH 1..8, RD_LAT >= 1");
   end

   state_t          state, stateNext;
   logic [NCH-1:0]  pending, pendNext;
   logic [NCH-1:0]  grantMask, grantedMask, clrMask;
   logic [CH_W-1:0] grant, lastGrant, pickGrant;
   logic            pickFound;
   logic            rdEn, lastAddr;
   logic            ovfNext, ovf;
   logic [AW-1:0]   addr;
   logic [GW-1:0]   gapCnt;
   vtag_t           tagIn;
   vtag_t           pipe [RD_LAT];

   rr_pick #(.NCH(NCH), .CW(CH_W)) uPick (
      .req   (pending),
      .last  (lastGrant),
      .grant (pickGrant),
      .found (pickFound)
   );

   assign grantMask   = NCH'(1) << grant;
   assign grantedMask = ((state == READ) || (state == DONE)) ? grantMask : '0;
   assign clrMask     = (state == DONE) ? grantMask : '0;
   // A new request beats the DONE clear, so a channel overwritten mid-read is re-queued.
   assign pendNext    = (pending & ~clrMask) | bus.iDone;
   assign ovfNext     = |(bus.iDone & (pending | grantedMask));
   assign lastAddr    = (addr == AW'(WORDS - 1));

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // FSM next state and read strobe.
   always_comb begin
      stateNext = state;
      rdEn      = 1'b0;
      unique case (state)
         IDLE: if (|pending) stateNext = ARB;
         ARB:  stateNext = pickFound ? READ : IDLE;
         READ: begin
            if (gapCnt == '0) begin
               rdEn = 1'b1;
               if (lastAddr) stateNext = DONE;
            end
         end
         DONE: stateNext = (|pendNext) ? ARB : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Request bookkeeping, grant, address and gap counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         ovf       <= 1'b0;
         grant     <= '0;
         lastGrant <= CH_W'(NCH - 1);
         addr      <= '0;
         gapCnt    <= '0;
      end else begin
         pending <= pendNext;
         ovf     <= ovfNext;
         unique case (state)
            ARB: begin
               if (pickFound) begin
                  grant     <= pickGrant;
                  lastGrant <= pickGrant;
               end
               addr   <= '0;
               gapCnt <= '0;
            end
            READ: begin
               // The address advances on the last gap cycle so the next read sees it.
               if (gapCnt == '0) begin
                  if (!lastAddr) begin
                     if (GAP == 0) addr   <= addr + 1'b1;
                     else          gapCnt <= GW'(GAP);
                  end
               end else begin
                  gapCnt <= gapCnt - 1'b1;
                  if (gapCnt == GW'(1)) addr <= addr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign tagIn.valid = rdEn;
   assign tagIn.ch    = 3'(grant);
   assign tagIn.first = rdEn && (addr == '0);
   assign tagIn.last  = rdEn && lastAddr;

   // Delay the read tag by the buffer read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= tagIn;
         for (int unsigned i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i - 1];
      end
   end

   assign bus.oRd    = rdEn ? grantMask : '0;
   assign bus.oRdAdr = addr;
   assign bus.oBusy  = (state != IDLE);
   assign bus.oOvf   = ovf;
   assign bus.oValid = pipe[RD_LAT - 1].valid;
   assign bus.oValCh = pipe[RD_LAT - 1].ch;
   assign bus.oFirst = pipe[RD_LAT - 1].first;
   assign bus.oLast  = pipe[RD_LAT - 1].last;

`ifdef DROP_CNT_EN
   logic [7:0] dropCnt;

   // Saturating count of lost/overwritten requests.
   always_ff @(posedge clk) begin
      if (rst)                          dropCnt <= '0;
      else if (ovfNext && dropCnt != '1) dropCnt <= dropCnt + 1'b1;
   end

   assign bus.oDropCnt = dropCnt;
`endif

endmodule

// File: tb/tb_uart_buf_rd_sched.sv
// Directed bench for uart_buf_rd_sched: default DUT (WORDS=20, GAP=3) plus a
// GAP=0, WORDS=32 instance. Reads and valids are logged each cycle and compared
// against hand-derived timing: packet p byte k read at c0+3+79p+4k.
module tb_uart_buf_rd_sched;

   typedef struct {
      int   cyc;
      int   ch;
      int   adr;
      logic first;
      logic last;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   nChecks = 0;
   int   nPass = 0;
   int   ovfCnt = 0;
   ev_t  rdQ[$];
   ev_t  vaQ[$];
   ev_t  rdQ6[$];
   ev_t  vaQ6[$];

   uart_buf_rd_sched_if #(.NCH(5), .AW(5)) bus ();
   uart_buf_rd_sched_if #(.NCH(5), .AW(5)) bus6 ();

   uart_buf_rd_sched #(.NCH(5), .AW(5), .WORDS(20), .GAP(3), .RD_LAT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   uart_buf_rd_sched #(.NCH(5), .AW(5), .WORDS(32), .GAP(0), .RD_LAT(1)) dut6 (
      .clk (clk),
      .rst (rst),
      .bus (bus6.master)
   );

   always #5 clk = ~clk;

   // Cycle counter, advanced on every active edge.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ohIdx(input logic [4:0] v);
      int r = -1;
      int n = 0;
      for (int i = 0; i < 5; i++) begin
         if (v[i]) begin
            r = i;
            n++;
         end
      end
      if (n != 1) r = -1;
      return r;
   endfunction

   // Log read strobes, valids and overflow pulses mid-cycle.
   always @(negedge clk) begin
      ev_t e;
      if (bus.oRd != '0) begin
         e = '{cyc, ohIdx(bus.oRd), int'(bus.oRdAdr), 1'b0, 1'b0};
         rdQ.push_back(e);
      end
      if (bus.oValid) begin
         e = '{cyc, int'(bus.oValCh), 0, bus.oFirst, bus.oLast};
         vaQ.push_back(e);
      end
      if (bus.oOvf) ovfCnt++;
      if (bus6.oRd != '0) begin
         e = '{cyc, ohIdx(bus6.oRd), int'(bus6.oRdAdr), 1'b0, 1'b0};
         rdQ6.push_back(e);
      end
      if (bus6.oValid) begin
         e = '{cyc, int'(bus6.oValCh), 0, bus6.oFirst, bus6.oLast};
         vaQ6.push_back(e);
      end
   end

   task automatic checkVal(input string tag, input int got, input int exp);
      nChecks++;
      if (got == exp) nPass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitTo(input int c);
      while (cyc < c) tick();
   endtask

   task automatic clearLogs();
      rdQ.delete();
      vaQ.delete();
      rdQ6.delete();
      vaQ6.delete();
      ovfCnt = 0;
   endtask

   task automatic doReset();
      rst = 1'b1;
      bus.iDone = '0;
      bus6.iDone = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      clearLogs();
   endtask

   task automatic pulse(input logic [4:0] v, output int c);
      bus.iDone = v;
      c = cyc;
      tick();
      bus.iDone = '0;
   endtask

   // Packets of 20 bytes, GAP=3: byte k of packet p read at c0+3+79p+4k.
   task automatic checkReads(input string tag, input int c0, input int nPk,
                             input int ch0, input int ch1, input int ch2);
      int chs[3];
      int n;
      int p;
      int k;
      chs[0] = ch0;
      chs[1] = ch1;
      chs[2] = ch2;
      n = 20 * nPk;
      checkVal({tag, ".nRd"}, rdQ.size(), n);
      checkVal({tag, ".nValid"}, vaQ.size(), n);
      for (int i = 0; i < n && i < rdQ.size(); i++) begin
         p = i / 20;
         k = i % 20;
         checkVal($sformatf("%s.rd%0d.cyc", tag, i), rdQ[i].cyc, c0 + 3 + 79 * p + 4 * k);
         checkVal($sformatf("%s.rd%0d.ch", tag, i), rdQ[i].ch, chs[p]);
         checkVal($sformatf("%s.rd%0d.adr", tag, i), rdQ[i].adr, k);
      end
      for (int i = 0; i < n && i < vaQ.size(); i++) begin
         p = i / 20;
         k = i % 20;
         checkVal($sformatf("%s.va%0d.cyc", tag, i), vaQ[i].cyc, c0 + 4 + 79 * p + 4 * k);
         checkVal($sformatf("%s.va%0d.ch", tag, i), vaQ[i].ch, chs[p]);
         checkVal($sformatf("%s.va%0d.first", tag, i), int'(vaQ[i].first), (k == 0) ? 1 : 0);
         checkVal($sformatf("%s.va%0d.last", tag, i), int'(vaQ[i].last), (k == 19) ? 1 : 0);
      end
   endtask

   initial begin
      int c0;
      int c1;
      bus.iDone = '0;
      bus6.iDone = '0;
      rst = 1'b1;
      tick();
      tick();

      // Reset state
      checkVal("rst.oRd", int'(bus.oRd), 0);
      checkVal("rst.oRdAdr", int'(bus.oRdAdr), 0);
      checkVal("rst.oValid", int'(bus.oValid), 0);
      checkVal("rst.oValCh", int'(bus.oValCh), 0);
      checkVal("rst.oBusy", int'(bus.oBusy), 0);
      checkVal("rst.oOvf", int'(bus.oOvf), 0);
`ifdef DROP_CNT_EN
      checkVal("rst.oDropCnt", int'(bus.oDropCnt), 0);
`endif
      rst = 1'b0;
      tick();
      clearLogs();

      // 1: single packet on ch2
      pulse(5'b00100, c0);
      waitTo(c0 + 40);
      checkVal("t1.busyMid", int'(bus.oBusy), 1);
      waitTo(c0 + 90);
      checkReads("t1", c0, 1, 2, 0, 0);
      checkVal("t1.busyEnd", int'(bus.oBusy), 0);
      checkVal("t1.ovf", ovfCnt, 0);

      // 2: three simultaneous requests, serviced 0,1,4 back-to-back
      doReset();
      pulse(5'b10011, c0);
      waitTo(c0 + 245);
      checkReads("t2", c0, 3, 0, 1, 4);
      checkVal("t2.ovf", ovfCnt, 0);

      // 3: after ch1 was served, ch3 beats ch0
      doReset();
      pulse(5'b00010, c0);
      waitTo(c0 + 85);
      clearLogs();
      pulse(5'b01001, c1);
      waitTo(c1 + 165);
      checkReads("t3", c1, 2, 3, 0, 0);

      // 4: ch0 requested twice while ch2 reads -> one overflow, one ch0 packet
      doReset();
      pulse(5'b00100, c0);
      waitTo(c0 + 20);
      pulse(5'b00001, c1);
      waitTo(c0 + 30);
      pulse(5'b00001, c1);
      waitTo(c0 + 170);
      checkReads("t4", c0, 2, 2, 0, 0);
      checkVal("t4.ovfPulses", ovfCnt, 1);
`ifdef DROP_CNT_EN
      checkVal("t4.oDropCnt", int'(bus.oDropCnt), 1);
`endif

      // 5: reset mid-packet on ch1 at address 7
      doReset();
      pulse(5'b00010, c0);
      waitTo(c0 + 31);
      checkVal("t5.preRd", int'(bus.oRd), 5'b00010);
      checkVal("t5.preAdr", int'(bus.oRdAdr), 7);
      rst = 1'b1;
      tick();
      checkVal("t5.rstRd", int'(bus.oRd), 0);
      checkVal("t5.rstBusy", int'(bus.oBusy), 0);
      checkVal("t5.rstValid", int'(bus.oValid), 0);
      rst = 1'b0;
      clearLogs();
      repeat (10) tick();
      checkVal("t5.noStaleRd", rdQ.size(), 0);
      clearLogs();
      pulse(5'b10001, c1);
      waitTo(c1 + 165);
      checkReads("t5", c1, 2, 0, 4, 0);

      // 6: GAP=0, WORDS=32 -> 32 consecutive reads, adr 0..31
      doReset();
      bus6.iDone = 5'b00001;
      c0 = cyc;
      tick();
      bus6.iDone = '0;
      waitTo(c0 + 45);
      checkVal("t6.nRd", rdQ6.size(), 32);
      checkVal("t6.nValid", vaQ6.size(), 32);
      for (int i = 0; i < 32 && i < rdQ6.size(); i++) begin
         checkVal($sformatf("t6.rd%0d.cyc", i), rdQ6[i].cyc, c0 + 3 + i);
         checkVal($sformatf("t6.rd%0d.adr", i), rdQ6[i].adr, i);
         checkVal($sformatf("t6.rd%0d.ch", i), rdQ6[i].ch, 0);
      end
      for (int i = 0; i < 32 && i < vaQ6.size(); i++) begin
         checkVal($sformatf("t6.va%0d.first", i), int'(vaQ6[i].first), (i == 0) ? 1 : 0);
         checkVal($sformatf("t6.va%0d.last", i), int'(vaQ6[i].last), (i == 31) ? 1 : 0);
      end
      checkVal("t6.busyEnd", int'(bus6.oBusy), 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
